gpu_cmd_sender: RTL and testbench

CPU-side transmitter for the GPU text-mode command port. It accepts high-level text requests (put char, set column/row, newline, display, clear) over a valid/ready handshake. It translates each request into zero, one or two single-cycle GPU commands on the 2-bit command / 8-bit data / enable bus. It keeps a shadow copy of the GPU text cursor so that absolute cursor requests can be converted into the relative moves the GPU understands.

---
 rtl/gpu_cmd_sender.sv | 188 ++++++++++++++++++
 tb/tb_gpu_cmd_sender.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/gpu_cmd_sender.sv
// Text-mode request front end for the GPU command port: turns cursor/char requests
// into single-cycle GPU commands while tracking a shadow copy of the GPU cursor.
module gpu_cmd_sender #(
    parameter int unsigned CMD_GAP = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [7:0] req_data,
    output logic [1:0] gpu_interrupt,
    output logic [7:0] gpu_data,
    output logic       gpu_interrupt_enable,
    output logic [6:0] cursor_x,
    output logic [5:0] cursor_y,
    output logic       err
);

    typedef enum logic [1:0] {StIdle, StSendX, StSendY, StGap} state_e;

    localparam logic [3:0] GapLoad = (CMD_GAP == 0) ? 4'd0 : 4'(CMD_GAP - 1);
    localparam state_e StDone = (CMD_GAP == 0) ? StIdle : StGap;

    state_e     state_q;
    logic [3:0] gap_cnt_q;
    logic       row_pend_q;
    logic [5:0] dy_pend_q;
    logic [6:0] tgt_x_q;
    logic [5:0] tgt_y_q;

    logic       accept;
    logic       reject;
    logic [1:0] n_cmds;
    logic       first_row;
    logic [1:0] first_code;
    logic [7:0] first_data;
    logic [6:0] nx;
    logic [5:0] ny;
    logic [6:0] dx_set;
    logic [5:0] dy_set;
    logic [6:0] dx_nl;
    logic [5:0] dy_nl;
    logic [5:0] y_inc;

    assign req_ready = (state_q == StIdle) & ~rst;
    assign accept    = req_valid & req_ready;

    // Deltas wrap in the GPU's field width, so plain modular subtraction is exact.
    assign dx_set = req_data[6:0] - cursor_x;
    assign dy_set = req_data[5:0] - cursor_y;
    assign y_inc  = (cursor_y == 6'd59) ? 6'd0 : cursor_y + 6'd1;
    assign dx_nl  = 7'd0 - cursor_x;
    assign dy_nl  = y_inc - cursor_y;

    always_comb begin
        reject     = 1'b0;
        n_cmds     = 2'd0;
        first_row  = 1'b0;
        first_code = 2'b00;
        first_data = 8'h00;
        nx         = cursor_x;
        ny         = cursor_y;
        case (req_op)
            3'd0: begin
                n_cmds     = 2'd1;
                first_data = req_data;
                nx         = (cursor_x == 7'd79) ? 7'd0 : cursor_x + 7'd1;
                ny         = (cursor_x == 7'd79) ? y_inc : cursor_y;
            end
            3'd1: begin
                if (req_data[6:0] > 7'd79) begin
                    reject = 1'b1;
                end else begin
                    nx         = req_data[6:0];
                    n_cmds     = (dx_set != 7'd0) ? 2'd1 : 2'd0;
                    first_code = 2'b01;
                    first_data = {1'b1, dx_set};
                end
            end
            3'd2: begin
                if (req_data[5:0] > 6'd59) begin
                    reject = 1'b1;
                end else begin
                    ny         = req_data[5:0];
                    n_cmds     = (dy_set != 6'd0) ? 2'd1 : 2'd0;
                    first_row  = 1'b1;
                    first_code = 2'b01;
                    first_data = {2'b00, dy_set};
                end
            end
            3'd3: begin
                nx         = 7'd0;
                ny         = y_inc;
                first_code = 2'b01;
                if (dx_nl != 7'd0) begin
                    n_cmds     = (dy_nl != 6'd0) ? 2'd2 : 2'd1;
                    first_data = {1'b1, dx_nl};
                end else if (dy_nl != 6'd0) begin
                    n_cmds     = 2'd1;
                    first_row  = 1'b1;
                    first_data = {2'b00, dy_nl};
                end
            end
            3'd4: begin
                n_cmds     = 2'd1;
                first_code = 2'b10;
            end
            3'd5: begin
                n_cmds     = 2'd1;
                first_code = 2'b11;
            end
            default: reject = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q              <= StIdle;
            gap_cnt_q            <= 4'd0;
            row_pend_q           <= 1'b0;
            dy_pend_q            <= 6'd0;
            tgt_x_q              <= 7'd0;
            tgt_y_q              <= 6'd0;
            gpu_interrupt        <= 2'b00;
            gpu_data             <= 8'h00;
            gpu_interrupt_enable <= 1'b0;
            cursor_x             <= 7'd0;
            cursor_y             <= 6'd0;
            err                  <= 1'b0;
        end else begin
            gpu_interrupt_enable <= 1'b0;
            err                  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (reject) begin
                            err <= 1'b1;
                        end else begin
                            // Two-command requests commit the cursor with the second strobe.
                            if (n_cmds != 2'd2) begin
                                cursor_x <= nx;
                                cursor_y <= ny;
                            end
                            tgt_x_q    <= nx;
                            tgt_y_q    <= ny;
                            dy_pend_q  <= dy_nl;
                            row_pend_q <= (n_cmds == 2'd2);
                            if (n_cmds != 2'd0) begin
                                gpu_interrupt_enable <= 1'b1;
                                gpu_interrupt        <= first_code;
                                gpu_data             <= first_data;
                                state_q              <= first_row ? StSendY : StSendX;
                            end
                        end
                    end
                end
                StSendX: begin
                    if (row_pend_q) begin
                        gpu_interrupt_enable <= 1'b1;
                        gpu_interrupt        <= 2'b01;
                        gpu_data             <= {2'b00, dy_pend_q};
                        cursor_x             <= tgt_x_q;
                        cursor_y             <= tgt_y_q;
                        row_pend_q           <= 1'b0;
                        state_q              <= StSendY;
                    end else begin
                        gap_cnt_q <= GapLoad;
                        state_q   <= StDone;
                    end
                end
                StSendY: begin
                    gap_cnt_q <= GapLoad;
                    state_q   <= StDone;
                end
                StGap: begin
                    if (gap_cnt_q == 4'd0) begin
                        state_q <= StIdle;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_cmd_sender.sv
// Directed bench for gpu_cmd_sender: one instance without command gap, one with CMD_GAP=3.
module tb_gpu_cmd_sender;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, valid0, ready0, en0, err0;
    logic [2:0] op0;
    logic [7:0] data0, gdata0;
    logic [1:0] gint0;
    logic [6:0] cx0;
    logic [5:0] cy0;

    logic       rst1, valid1, ready1, en1, err1;
    logic [2:0] op1;
    logic [7:0] data1, gdata1;
    logic [1:0] gint1;
    logic [6:0] cx1;
    logic [5:0] cy1;

    int n_vec = 0;
    int n_err = 0;

    gpu_cmd_sender #(.CMD_GAP(0)) u_dut0 (
        .clk(clk), .rst(rst0), .req_valid(valid0), .req_ready(ready0), .req_op(op0),
        .req_data(data0), .gpu_interrupt(gint0), .gpu_data(gdata0),
        .gpu_interrupt_enable(en0), .cursor_x(cx0), .cursor_y(cy0), .err(err0)
    );

    gpu_cmd_sender #(.CMD_GAP(3)) u_dut1 (
        .clk(clk), .rst(rst1), .req_valid(valid1), .req_ready(ready1), .req_op(op1),
        .req_data(data1), .gpu_interrupt(gint1), .gpu_data(gdata1),
        .gpu_interrupt_enable(en1), .cursor_x(cx1), .cursor_y(cy1), .err(err1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request to instance 0 for a single cycle; returns in cycle T+1.
    task automatic send0(input logic [2:0] op, input logic [7:0] data);
        valid0 = 1'b1;
        op0    = op;
        data0  = data;
        step();
        valid0 = 1'b0;
    endtask

    task automatic idle0(input string tag);
        for (int i = 0; i < 20 && !ready0; i++) step();
        check(tag, ready0, 1'b1);
    endtask

    int s0, s1, nstrobe, extra;

    initial begin
        rst0 = 1'b1; valid0 = 1'b0; op0 = 3'd0; data0 = 8'h00;
        rst1 = 1'b1; valid1 = 1'b0; op1 = 3'd0; data1 = 8'h00;
        step();
        step();
        check("rst_ready", ready0, 1'b0);
        check("rst_en", en0, 1'b0);
        check("rst_int_data", {gint0, gdata0}, 10'h000);
        check("rst_cursor", {cx0, cy0}, 13'h0);
        check("rst_err", err0, 1'b0);
        rst0 = 1'b0;
        #1;
        check("ready_after_rst", ready0, 1'b1);

        // PUT_CHAR 0x41
        send0(3'd0, 8'h41);
        check("put_en", en0, 1'b1);
        check("put_cmd", {gint0, gdata0}, {2'b00, 8'h41});
        check("put_cursor", {cx0, cy0}, {7'd1, 6'd0});
        check("put_busy", ready0, 1'b0);
        step();
        check("put_en_drop", en0, 1'b0);
        check("put_ready_t2", ready0, 1'b1);

        // SET_X sequence
        send0(3'd1, 8'd5);
        check("setx5_cmd", {gint0, gdata0}, {2'b01, 8'h84});
        idle0("setx5_idle");
        send0(3'd1, 8'd10);
        check("setx10_cmd", {en0, gint0, gdata0}, {1'b1, 2'b01, 8'h85});
        idle0("setx10_idle");
        send0(3'd1, 8'd3);
        check("setx3_cmd", {en0, gint0, gdata0}, {1'b1, 2'b01, 8'hF9});
        check("setx3_cursor", cx0, 7'd3);
        idle0("setx3_idle");
        send0(3'd1, 8'd3);
        check("setx_noop_en", en0, 1'b0);
        check("setx_noop_ready", ready0, 1'b1);
        check("setx_noop_err", err0, 1'b0);
        check("setx_noop_cursor", cx0, 7'd3);

        // NEWLINE from (79,59)
        send0(3'd1, 8'd79);
        idle0("to79_idle");
        send0(3'd2, 8'd59);
        check("sety59_cmd", {en0, gint0, gdata0}, {1'b1, 2'b01, 8'h3B});
        idle0("to59_idle");
        send0(3'd3, 8'h00);
        check("nl_col", {en0, gint0, gdata0}, {1'b1, 2'b01, 8'hB1});
        check("nl_cursor_hold", {cx0, cy0}, {7'd79, 6'd59});
        step();
        check("nl_row", {en0, gint0, gdata0}, {1'b1, 2'b01, 8'h05});
        check("nl_cursor", {cx0, cy0}, 13'h0);
        step();
        check("nl_en_drop", en0, 1'b0);
        check("nl_ready", ready0, 1'b1);

        // PUT_CHAR wrap from (79,59)
        send0(3'd1, 8'd79);
        check("setx79_cmd", gdata0, 8'hCF);
        idle0("wrap_x_idle");
        send0(3'd2, 8'd59);
        idle0("wrap_y_idle");
        send0(3'd0, 8'h20);
        check("wrap_cmd", {en0, gint0, gdata0}, {1'b1, 2'b00, 8'h20});
        check("wrap_cursor", {cx0, cy0}, 13'h0);
        step();
        check("wrap_single", en0, 1'b0);

        // Rejects and CLEAR from (1,0)
        send0(3'd0, 8'h7E);
        idle0("rej_pre_idle");
        send0(3'd1, 8'd80);
        check("rej_x", {err0, en0, ready0}, 3'b101);
        check("rej_x_cursor", {cx0, cy0}, {7'd1, 6'd0});
        send0(3'd2, 8'd60);
        check("rej_y", {err0, en0, ready0}, 3'b101);
        check("rej_y_cursor", {cx0, cy0}, {7'd1, 6'd0});
        send0(3'd7, 8'h00);
        check("rej_op7", {err0, en0, ready0}, 3'b101);
        step();
        check("rej_err_pulse", err0, 1'b0);
        send0(3'd5, 8'hAA);
        check("clear_cmd", {en0, gint0, gdata0}, {1'b1, 2'b11, 8'h00});
        check("clear_cursor", {cx0, cy0}, {7'd1, 6'd0});

        // NEWLINE from column 0: row move only, on T+1
        idle0("nl0_pre");
        send0(3'd1, 8'd0);
        idle0("nl0_pre2");
        send0(3'd3, 8'h00);
        check("nl0_row", {en0, gint0, gdata0}, {1'b1, 2'b01, 8'h01});
        check("nl0_cursor", {cx0, cy0}, {7'd0, 6'd1});
        step();
        check("nl0_single", en0, 1'b0);

        // CMD_GAP=3 instance
        rst1 = 1'b0;
        #1;
        valid1 = 1'b1; op1 = 3'd1; data1 = 8'd5;
        step();
        valid1 = 1'b0;
        check("g_setx", {en1, gint1, gdata1}, {1'b1, 2'b01, 8'h85});
        step();
        check("g_gap_busy", ready1, 1'b0);
        for (int i = 0; i < 20 && !ready1; i++) step();
        check("g_ready", ready1, 1'b1);
        valid1 = 1'b1; op1 = 3'd4; data1 = 8'h55;
        s0 = -1; s1 = -1; nstrobe = 0;
        for (int k = 0; k < 30 && nstrobe < 2; k++) begin
            step();
            if (en1) begin
                check("g_disp_cmd", {gint1, gdata1}, {2'b10, 8'h00});
                if (nstrobe == 0) s0 = k; else s1 = k;
                nstrobe++;
            end
        end
        valid1 = 1'b0;
        check("g_strobes", nstrobe, 2);
        check("g_spacing", s1 - s0, 5);
        step();
        step();
        rst1 = 1'b1;
        step();
        rst1 = 1'b0;
        check("g_rst_en", en1, 1'b0);
        check("g_rst_cursor", {cx1, cy1}, 13'h0);
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (en1) extra++;
        end
        check("g_no_strobe", extra, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
